// File: rtl/tmr_err_monitor.sv
// Error-sink monitor for triplicated logic: sticky status, fault count, windowed resync handshake.
// Optional capture of the first-event cycle: define TMR_ERR_MONITOR_TIMESTAMP_EN.
module tmr_err_monitor #(
   parameter int N_SINKS  = 4,
   parameter int CNT_W    = 16,
   parameter int THRESH   = 3,
   parameter int WINDOW   = 256,
   parameter int COOLDOWN = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_SINKS-1:0] err_in,
   input  logic               clr,
   input  logic               resync_ack,
   output logic               irq,
   output logic [N_SINKS-1:0] sticky,
   output logic [CNT_W-1:0]   fault_cnt,
   output logic               resync_req,
   output logic [CNT_W-1:0]   resync_cnt,
   output logic               busy
`ifdef TMR_ERR_MONITOR_TIMESTAMP_EN
   ,
   output logic [CNT_W-1:0]   first_ts
`endif
);

   localparam int WC_W = $clog2(THRESH + 1);
   localparam int WT_W = $clog2(WINDOW);
   localparam int CD_W = $clog2(COOLDOWN + 1);

   localparam logic [WC_W-1:0] THR_M1 = WC_W'(THRESH - 1);
   localparam logic [WT_W-1:0] WIN_M1 = WT_W'(WINDOW - 1);
   localparam logic [CD_W-1:0] CD_M1  = CD_W'(COOLDOWN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_RESYNC,
      S_COOL
   } state_t;

   state_t state_q, state_d;

   logic [N_SINKS-1:0] err_q;
   logic [N_SINKS-1:0] rise;
   logic               ev;

   logic [WC_W-1:0] win_cnt_q, win_cnt_d;
   logic [WT_W-1:0] win_tmr_q, win_tmr_d;
   logic [CD_W-1:0] cd_q, cd_d;
   logic            rs_done;

   assign rise = err_in & ~err_q;
   assign ev   = |rise;

   assign irq        = |sticky;
   assign resync_req = (state_q == S_RESYNC);
   assign busy       = (state_q == S_RESYNC) || (state_q == S_COOL);

   always_comb begin
      state_d   = state_q;
      win_cnt_d = win_cnt_q;
      win_tmr_d = win_tmr_q;
      cd_d      = cd_q;
      rs_done   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (ev) begin
               if (THRESH == 1) begin
                  state_d = S_RESYNC;
               end else begin
                  state_d   = S_ARMED;
                  win_cnt_d = WC_W'(1);
                  win_tmr_d = WT_W'(1);
               end
            end
         end
         S_ARMED: begin
            win_tmr_d = win_tmr_q + 1'b1;
            // threshold hit on the expiry cycle beats expiry
            if (ev && (win_cnt_q == THR_M1)) begin
               state_d   = S_RESYNC;
               win_cnt_d = '0;
               win_tmr_d = '0;
            end else if (win_tmr_q == WIN_M1) begin
               state_d   = S_IDLE;
               win_cnt_d = '0;
               win_tmr_d = '0;
            end else if (ev) begin
               win_cnt_d = win_cnt_q + 1'b1;
            end
         end
         S_RESYNC: begin
            if (resync_ack) begin
               state_d = S_COOL;
               cd_d    = '0;
               rs_done = 1'b1;
            end
         end
         S_COOL: begin
            cd_d = cd_q + 1'b1;
            if (cd_q == CD_M1) begin
               state_d = S_IDLE;
               cd_d    = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         win_cnt_q  <= '0;
         win_tmr_q  <= '0;
         cd_q       <= '0;
         err_q      <= '0;
         sticky     <= '0;
         fault_cnt  <= '0;
         resync_cnt <= '0;
      end else begin
         state_q   <= state_d;
         win_cnt_q <= win_cnt_d;
         win_tmr_q <= win_tmr_d;
         cd_q      <= cd_d;
         err_q     <= err_in;
         sticky    <= (clr ? '0 : sticky) | rise;
         if (clr) begin
            fault_cnt <= CNT_W'(ev);
         end else if (ev && (fault_cnt != '1)) begin
            fault_cnt <= fault_cnt + 1'b1;
         end
         if (rs_done && (resync_cnt != '1)) begin
            resync_cnt <= resync_cnt + 1'b1;
         end
      end
   end

`ifdef TMR_ERR_MONITOR_TIMESTAMP_EN
   logic [CNT_W-1:0] ts_q;
   logic             ts_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q     <= '0;
         ts_done  <= 1'b0;
         first_ts <= '0;
      end else begin
         ts_q <= ts_q + 1'b1;
         if (clr) begin
            first_ts <= ev ? ts_q : '0;
            ts_done  <= ev;
         end else if (ev && !ts_done) begin
            first_ts <= ts_q;
            ts_done  <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_tmr_err_monitor.sv
// Directed testbench for tmr_err_monitor (default build) plus a CNT_W=4 saturation instance.
module tb_tmr_err_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  err_in;
   logic        clr;
   logic        resync_ack;
   logic        irq;
   logic [3:0]  sticky;
   logic [15:0] fault_cnt;
   logic        resync_req;
   logic [15:0] resync_cnt;
   logic        busy;

   logic        err2;
   logic        zero;
   logic        irq2;
   logic [0:0]  sticky2;
   logic [3:0]  fault2;
   logic        req2;
   logic [3:0]  rcnt2;
   logic        busy2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   tmr_err_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .err_in     (err_in),
      .clr        (clr),
      .resync_ack (resync_ack),
      .irq        (irq),
      .sticky     (sticky),
      .fault_cnt  (fault_cnt),
      .resync_req (resync_req),
      .resync_cnt (resync_cnt),
      .busy       (busy)
   );

   tmr_err_monitor #(.N_SINKS(1), .CNT_W(4)) u_sat (
      .clk        (clk),
      .rst        (rst),
      .err_in     (err2),
      .clr        (zero),
      .resync_ack (zero),
      .irq        (irq2),
      .sticky     (sticky2),
      .fault_cnt  (fault2),
      .resync_req (req2),
      .resync_cnt (rcnt2),
      .busy       (busy2)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [3:0] m);
      err_in = m;
      tick(1);
      err_in = '0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      err_in = '0;
      clr = 1'b0;
      resync_ack = 1'b0;
      err2 = 1'b0;
      zero = 1'b0;
      tick(2);
      rst = 1'b0;
      chk("rst_irq", irq, 0);
      chk("rst_sticky", sticky, 0);
      chk("rst_fault", fault_cnt, 0);
      chk("rst_req", resync_req, 0);
      chk("rst_rcnt", resync_cnt, 0);
      chk("rst_busy", busy, 0);

      // single pulse on bit 2
      tick(1);
      pulse(4'b0100);
      chk("p1_sticky", sticky, 4'b0100);
      chk("p1_irq", irq, 1);
      chk("p1_fault", fault_cnt, 1);
      chk("p1_busy", busy, 0);
      tick(300);
      chk("p1_req", resync_req, 0);
      do_clr();
      chk("clr_sticky", sticky, 0);
      chk("clr_fault", fault_cnt, 0);
      chk("clr_irq", irq, 0);

      // held level counts once, then simultaneous rises
      err_in = 4'b0001;
      tick(50);
      chk("lvl_fault", fault_cnt, 1);
      err_in = 4'b1011;
      tick(1);
      chk("sim_fault", fault_cnt, 2);
      chk("sim_sticky", sticky, 4'b1011);
      err_in = '0;
      tick(300);
      chk("two_ev_req", resync_req, 0);
      do_clr();

      // three events in window -> resync
      pulse(4'b0100);
      tick(89);
      pulse(4'b0100);
      chk("w2_req", resync_req, 0);
      tick(99);
      pulse(4'b0100);
      chk("w3_req", resync_req, 1);
      chk("w3_busy", busy, 1);
      chk("w3_fault", fault_cnt, 3);
      tick(3);
      chk("hold_req", resync_req, 1);
      resync_ack = 1'b1;
      tick(1);
      resync_ack = 1'b0;
      chk("ack_req", resync_req, 0);
      chk("ack_rcnt", resync_cnt, 1);
      chk("ack_busy", busy, 1);
      tick(15);
      chk("cd_busy_last", busy, 1);
      tick(1);
      chk("cd_done", busy, 0);
      resync_ack = 1'b1;
      tick(1);
      resync_ack = 1'b0;
      chk("stray_ack", resync_cnt, 1);
      do_clr();

      // pulses at 0,100,300: window expires, third re-arms at count 1
      pulse(4'b0001);
      tick(99);
      pulse(4'b0001);
      tick(199);
      pulse(4'b0001);
      chk("exp_req", resync_req, 0);
      tick(9);
      pulse(4'b0001);
      chk("rearm2_req", resync_req, 0);
      tick(9);
      pulse(4'b0001);
      chk("rearm3_req", resync_req, 1);

      // reset while requesting
      tick(2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("mid_rst_req", resync_req, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rcnt", resync_cnt, 0);
      chk("mid_rst_fault", fault_cnt, 0);
      chk("mid_rst_sticky", sticky, 0);

      // clr coincident with a rise
      pulse(4'b0100);
      tick(1);
      clr = 1'b1;
      err_in = 4'b0010;
      tick(1);
      clr = 1'b0;
      err_in = '0;
      chk("clr_rise_sticky", sticky, 4'b0010);
      chk("clr_rise_fault", fault_cnt, 1);
      chk("clr_rise_irq", irq, 1);

      // 4-bit counter saturation
      for (int i = 0; i < 14; i++) begin
         err2 = 1'b1;
         tick(1);
         err2 = 1'b0;
         tick(1);
      end
      chk("sat_14", fault2, 14);
      for (int i = 0; i < 6; i++) begin
         err2 = 1'b1;
         tick(1);
         err2 = 1'b0;
         tick(1);
      end
      chk("sat_20", fault2, 15);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
